// File: rtl/ssd_pkg.sv
// -----------------------------------------------------------------------------
// ssd_pkg
// Shared constants for the seven-segment scan driver.
//   - Segment bit positions within the {g,f,e,d,c,b,a} bus.
//   - SEG_BLANK: all segments off (active-low bus).
//   - GLYPH_0 .. GLYPH_F: active-low hex glyphs.
// No ports (package).
// -----------------------------------------------------------------------------
package ssd_pkg;

    // Bit order of the segment bus: seg[6:0] = {g,f,e,d,c,b,a}
    localparam int SEG_A_BIT = 0;
    localparam int SEG_B_BIT = 1;
    localparam int SEG_C_BIT = 2;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 4;
    localparam int SEG_F_BIT = 5;
    localparam int SEG_G_BIT = 6;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low glyphs, {g,f,e,d,c,b,a}
    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b0000011;
    localparam logic [6:0] GLYPH_C = 7'b1000110;
    localparam logic [6:0] GLYPH_D = 7'b0100001;
    localparam logic [6:0] GLYPH_E = 7'b0000110;
    localparam logic [6:0] GLYPH_F = 7'b0001110;

endpackage : ssd_pkg

// File: rtl/ssd_glyph.sv
// -----------------------------------------------------------------------------
// ssd_glyph
// Combinational hex nibble to active-low seven-segment glyph lookup.
// Ports:
//   nibble_i  in  4  hex digit to display
//   seg_o     out 7  {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module ssd_glyph
    import ssd_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Nibble to glyph table lookup
    always_comb begin
        seg_o = SEG_BLANK;
        case (nibble_i)
            4'h0:    seg_o = GLYPH_0;
            4'h1:    seg_o = GLYPH_1;
            4'h2:    seg_o = GLYPH_2;
            4'h3:    seg_o = GLYPH_3;
            4'h4:    seg_o = GLYPH_4;
            4'h5:    seg_o = GLYPH_5;
            4'h6:    seg_o = GLYPH_6;
            4'h7:    seg_o = GLYPH_7;
            4'h8:    seg_o = GLYPH_8;
            4'h9:    seg_o = GLYPH_9;
            4'hA:    seg_o = GLYPH_A;
            4'hB:    seg_o = GLYPH_B;
            4'hC:    seg_o = GLYPH_C;
            4'hD:    seg_o = GLYPH_D;
            4'hE:    seg_o = GLYPH_E;
            4'hF:    seg_o = GLYPH_F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule : ssd_glyph

// File: rtl/ssd_scan.sv
// -----------------------------------------------------------------------------
// ssd_scan
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// A snapshot of the display word is captured on load; one digit is shown per
// refresh slot of REFRESH_DIV clocks. Supports per-digit blanking and
// leading-zero suppression. All display outputs are registered.
//
// Optional feature macro: SSD_DEADTIME_EN
//   defined   -> first DEAD_CYCLES clocks of every slot are fully dark
//   undefined -> anode switches directly at the slot boundary
//
// Ports:
//   clk         in   1             system clock
//   rst_n       in   1             asynchronous active-low reset
//   load        in   1             snapshot strobe
//   value       in   4*NUM_DIGITS  packed nibbles, digit 0 = [3:0]
//   dp_in       in   NUM_DIGITS    decimal point request, 1 = lit
//   blank_mask  in   NUM_DIGITS    1 = force digit dark
//   lz_en       in   1             leading-zero suppression enable
//   seg         out  7             {g,f,e,d,c,b,a}, active-low
//   dp          out  1             decimal point, active-low
//   an          out  NUM_DIGITS    anode enables, active-low
//   digit_idx   out  clog2(N)      index of digit currently shown
// -----------------------------------------------------------------------------
module ssd_scan
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            load,
    input  logic [4*NUM_DIGITS-1:0]         value,
    input  logic [NUM_DIGITS-1:0]           dp_in,
    input  logic [NUM_DIGITS-1:0]           blank_mask,
    input  logic                            lz_en,
    output logic [6:0]                      seg,
    output logic                            dp,
    output logic [NUM_DIGITS-1:0]           an,
    output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);

    // Elaboration-time guard against unsupported configurations
    if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || REFRESH_DIV < 4 ||
        DEAD_CYCLES < 0 || DEAD_CYCLES >= REFRESH_DIV) begin : g_param_check
        $error("ssd_scan: illegal parameter combination");
    end

    // Scan position
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]           idx_q, idx_d;

    // Snapshot
    logic [4*NUM_DIGITS-1:0]    snap_value_q;
    logic [NUM_DIGITS-1:0]      snap_dp_q;
    logic [NUM_DIGITS-1:0]      snap_blank_q;
    logic                       snap_lz_q;

    // Output registers
    logic [6:0]                 seg_q, seg_d;
    logic                       dp_q, dp_d;
    logic [NUM_DIGITS-1:0]      an_q, an_d;
    logic [IDX_W-1:0]           digit_idx_q, digit_idx_d;

    // Datapath helpers
    logic [3:0]                 nib_arr_s [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]      hi_zero_s;
    logic [3:0]                 nib_s;
    logic [6:0]                 glyph_s;
    logic                       blank_s;
    logic                       dead_s;

    // Split the snapshot into nibbles and flag, per index, whether that
    // nibble and every more-significant one are zero.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
        assign nib_arr_s[gi] = snap_value_q[4*gi +: 4];
        assign hi_zero_s[gi] = ~|snap_value_q[4*NUM_DIGITS-1 : 4*gi];
    end

    ssd_glyph u_glyph (
        .nibble_i (nib_s),
        .seg_o    (glyph_s)
    );

    // Refresh counter and digit index next-state
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_d = {CNT_W{1'b0}};
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                idx_d = {IDX_W{1'b0}};
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = idx_q;
        end
    end

    // Refresh counter and digit index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
            idx_q <= {IDX_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // Snapshot capture; the scan never looks at the live inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_value_q <= {(4*NUM_DIGITS){1'b0}};
            snap_dp_q    <= {NUM_DIGITS{1'b0}};
            snap_blank_q <= {NUM_DIGITS{1'b0}};
            snap_lz_q    <= 1'b0;
        end else if (load) begin
            snap_value_q <= value;
            snap_dp_q    <= dp_in;
            snap_blank_q <= blank_mask;
            snap_lz_q    <= lz_en;
        end
    end

    // Output word for the current index; everything below is computed from
    // registered state only, so a snapshot update lands as one whole word.
    always_comb begin
        nib_s       = nib_arr_s[idx_q];
        // Digit 0 is excluded so an all-zero word still shows a single 0
        blank_s     = snap_blank_q[idx_q] ||
                      (snap_lz_q && (idx_q != {IDX_W{1'b0}}) && hi_zero_s[idx_q]);
`ifdef SSD_DEADTIME_EN
        dead_s      = (cnt_q < CNT_W'(DEAD_CYCLES));
`else
        dead_s      = 1'b0;
`endif
        digit_idx_d = idx_q;
        an_d        = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q);
        seg_d       = SEG_BLANK;
        dp_d        = 1'b1;
        if (dead_s) begin
            an_d  = {NUM_DIGITS{1'b1}};
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end else if (blank_s) begin
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end else begin
            seg_d = glyph_s;
            dp_d  = ~snap_dp_q[idx_q];
        end
    end

    // Registered display outputs; reset drives the display dark at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
            an_q        <= {NUM_DIGITS{1'b1}};
            digit_idx_q <= {IDX_W{1'b0}};
        end else begin
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
            digit_idx_q <= digit_idx_d;
        end
    end

    assign seg       = seg_q;
    assign dp        = dp_q;
    assign an        = an_q;
    assign digit_idx = digit_idx_q;

endmodule : ssd_scan

// File: tb/tb_ssd_scan.sv
// -----------------------------------------------------------------------------
// tb_ssd_scan
// Directed self-checking bench for ssd_scan with NUM_DIGITS=4, REFRESH_DIV=4,
// DEAD_CYCLES=1. Expected per-digit glyph/dp tables are written by hand for
// each loaded word; the bench tracks the clock count since reset release to
// know which digit and slot position should be on display.
// -----------------------------------------------------------------------------
module tb_ssd_scan;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int DC = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank_mask;
    logic        lz_en;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  digit_idx;

    int n_cmp = 0;
    int n_err = 0;
    int k     = 0;   // posedges since reset release

    logic [6:0] tbl_seg [4];
    logic [3:0] tbl_dpl;   // expected active-low dp per digit

    ssd_scan #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .DEAD_CYCLES (DC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .blank_mask (blank_mask),
        .lz_en      (lz_en),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .digit_idx  (digit_idx)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (k=%0d): got %0h expected %0h", tag, k, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        k++;
        #1;
    endtask

    task automatic set_tbl(input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3,
                           input logic [3:0] dpl);
        tbl_seg[0] = s0;
        tbl_seg[1] = s1;
        tbl_seg[2] = s2;
        tbl_seg[3] = s3;
        tbl_dpl    = dpl;
    endtask

    // Compare all outputs against the table for the digit/slot position
    task automatic check_cycle(input string tag);
        int         d;
        int         p;
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;
        d  = ((k - 1) / RD) % ND;
        p  = (k - 1) % RD;
        ea = ~(4'b0001 << d);
        es = tbl_seg[d];
        ed = tbl_dpl[d];
`ifdef SSD_DEADTIME_EN
        if (p < DC) begin
            ea = 4'hF;
            es = 7'h7F;
            ed = 1'b1;
        end
`endif
        chk({tag, "_an"},  32'(an),  32'(ea));
        chk({tag, "_seg"}, 32'(seg), 32'(es));
        chk({tag, "_dp"},  32'(dp),  32'(ed));
        chk({tag, "_idx"}, 32'(digit_idx), 32'(d));
        chk({tag, "_an_onehot"}, 32'($countones(~an) <= 1), 32'd1);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step();
            check_cycle(tag);
        end
    endtask

    // Present a new word with load high for one edge; that edge still shows
    // the previous snapshot, so it is checked against the old table.
    task automatic apply_load(input logic [15:0] v, input logic [3:0] dpv,
                              input logic [3:0] bl, input logic lz, input string tag);
        value      = v;
        dp_in      = dpv;
        blank_mask = bl;
        lz_en      = lz;
        load       = 1'b1;
        step();
        check_cycle({tag, "_old"});
        load       = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        load       = 1'b0;
        value      = 16'h0000;
        dp_in      = 4'b0000;
        blank_mask = 4'b0000;
        lz_en      = 1'b0;
        set_tbl(7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 4'b1111);

        #12;
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp",  32'(dp),  32'd1);
        chk("rst_an",  32'(an),  32'hF);
        chk("rst_idx", 32'(digit_idx), 32'd0);

        rst_n = 1'b1;
        k     = 0;

        // Basic scan of 12AF
        apply_load(16'h12AF, 4'b0000, 4'b0000, 1'b0, "t1");
        set_tbl(7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001, 4'b1111);
        run(16, "t1");

        // Leading-zero suppression, 0005
        apply_load(16'h0005, 4'b0000, 4'b0000, 1'b1, "t2");
        set_tbl(7'b0010010, 7'h7F, 7'h7F, 7'h7F, 4'b1111);
        run(16, "t2");

        // All zero: digit 0 still shows 0
        apply_load(16'h0000, 4'b0000, 4'b0000, 1'b1, "t3");
        set_tbl(7'b1000000, 7'h7F, 7'h7F, 7'h7F, 4'b1111);
        run(16, "t3");

        // Inner zeros below a non-zero digit are not suppressed
        apply_load(16'h0A00, 4'b0000, 4'b0000, 1'b1, "t4");
        set_tbl(7'b1000000, 7'b1000000, 7'b0001000, 7'h7F, 4'b1111);
        run(16, "t4");

        // Decimal point on digit 2, digit 0 blanked by mask
        apply_load(16'h12AF, 4'b0100, 4'b0001, 1'b0, "t5");
        set_tbl(7'h7F, 7'b0001000, 7'b0100100, 7'b1111001, 4'b1011);
        run(16, "t5");

        // Load coincident with a slot wrap
        while (((k + 1) % RD) != 0) begin
            step();
            check_cycle("t6_align");
        end
        apply_load(16'hFFFF, 4'b0000, 4'b0000, 1'b0, "t6");
        set_tbl(7'b0001110, 7'b0001110, 7'b0001110, 7'b0001110, 4'b1111);
        run(8, "t6");

        // Asynchronous reset in the middle of digit 2's slot
        while (!((((k - 1) / RD) % ND) == 2 && ((k - 1) % RD) == 1)) begin
            step();
            check_cycle("t7_align");
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_seg", 32'(seg), 32'h7F);
        chk("t7_rst_dp",  32'(dp),  32'd1);
        chk("t7_rst_an",  32'(an),  32'hF);
        chk("t7_rst_idx", 32'(digit_idx), 32'd0);
        #2;
        rst_n = 1'b1;
        k     = 0;
        set_tbl(7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 4'b1111);
        run(8, "t7");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ssd_scan
